// File: rtl/fifo_push_arb2_pkg.sv
// Shared constants for the two-channel FIFO push arbiter.
// Channel count and default word width live here.
package fifo_push_arb2_pkg;
    localparam int N_CH           = 2;
    localparam int DEF_DATA_WIDTH = 4;
endpackage

// File: rtl/fifo_push_arb2_skid_buf2.sv
// Two-entry in-order buffer with occupancy counter.
// Storage is unreset; only pointers and count clear.
module skid_buf2
    import fifo_push_arb2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            cnt
);
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wptr;
    logic                  rptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok = wr && (cnt != 2'd2);
    assign rd_ok = rd && (cnt != 2'd0);
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else if (Reset) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (wr_ok) wptr <= ~wptr;
            if (rd_ok) rptr <= ~rptr;
            // Simultaneous write and read leaves the count unchanged
            unique case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/fifo_push_arb2.sv
// Two producer channels buffered and round-robin merged
// into a single downstream FIFO push port.
module fifo_push_arb2
    import fifo_push_arb2_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       Reset,
    input  logic [N_CH-1:0]            in_valid,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    output logic [N_CH-1:0]            in_ready,
    output logic                       push,
    output logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       full,
    output logic                       grant
);
    logic [1:0]            cnt   [N_CH];
    logic [DATA_WIDTH-1:0] rdata [N_CH];
    logic [N_CH-1:0]       req;
    logic [N_CH-1:0]       wr;
    logic [N_CH-1:0]       rd;
    logic                  rr;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign in_ready[i] = (cnt[i] != 2'd2);
        assign req[i]      = (cnt[i] != 2'd0);
        assign wr[i]       = in_valid[i] & in_ready[i];
        assign rd[i]       = push & (grant == 1'(i));

        skid_buf2 #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .Reset (Reset),
            .wr    (wr[i]),
            .wdata (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .rd    (rd[i]),
            .rdata (rdata[i]),
            .cnt   (cnt[i])
        );
    end

    assign push     = !full && (|req);
    assign data_out = rdata[grant];

    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            (req == 2'b11): grant = rr;
            (req == 2'b10): grant = 1'b1;
            default:        grant = 1'b0;
        endcase
    end

    // Pointer favours the channel that lost the last push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (Reset) begin
            rr <= 1'b0;
        end else if (push) begin
            rr <= ~grant;
        end
    end
endmodule

// File: tb/tb_fifo_push_arb2.sv
// Randomised bench for fifo_push_arb2 against a queue-based
// model of the per-channel buffers and round-robin merge.
module tb_fifo_push_arb2;
    logic       clk;
    logic       rst_n;
    logic       sreset;
    logic [1:0] in_valid;
    logic [7:0] in_data;
    logic [1:0] in_ready;
    logic       push;
    logic [3:0] data_out;
    logic       full;
    logic       grant;

    int n_vec;
    int n_err;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    bit         rr_m;
    logic [7:0] obs;
    logic [7:0] exp_v;

    fifo_push_arb2 #(.DATA_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Reset    (sreset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .push     (push),
        .data_out (data_out),
        .full     (full),
        .grant    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {in_ready, push, grant, data}; grant/data zeroed when idle
    function automatic logic [7:0] model_exp();
        logic [1:0] r;
        logic       p;
        logic       g;
        logic [3:0] d;
        r[0] = (q0.size() < 2);
        r[1] = (q1.size() < 2);
        p = !full && (q0.size() > 0 || q1.size() > 0);
        if (q0.size() > 0 && q1.size() > 0) g = rr_m;
        else g = (q1.size() > 0);
        d = 4'h0;
        if (p) d = g ? q1[0] : q0[0];
        if (!p) g = 1'b0;
        return {r, p, g, d};
    endfunction

    task automatic model_advance();
        logic [7:0] e;
        bit r0;
        bit r1;
        e  = model_exp();
        r0 = e[6];
        r1 = e[7];
        if (sreset) begin
            q0.delete();
            q1.delete();
            rr_m = 1'b0;
        end else begin
            if (e[5]) begin
                if (e[4]) void'(q1.pop_front());
                else void'(q0.pop_front());
                rr_m = !e[4];
            end
            if (in_valid[0] && r0) q0.push_back(in_data[3:0]);
            if (in_valid[1] && r1) q1.push_back(in_data[7:4]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 2'b00;
            full = 1'b0;
            #1;
            obs = {in_ready, push, push ? grant : 1'b0,
                   push ? data_out : 4'h0};
            n_vec++;
            if (obs !== 8'b11_0_0_0000) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %b want %b",
                         i, obs, 8'b11_0_0_0000);
            end
            model_advance();
        end
    endtask

    task automatic test_ch0_only();
        logic [3:0] words [3];
        words[0] = 4'h1;
        words[1] = 4'h2;
        words[2] = 4'h3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            full = 1'b0;
            in_valid = (i < 3) ? 2'b01 : 2'b00;
            in_data = {4'h0, (i < 3) ? words[i] : 4'h0};
            #1;
            exp_v = model_exp();
            obs = {in_ready, push, push ? grant : 1'b0,
                   push ? data_out : 4'h0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL ch0_only cyc %0d: got %b want %b",
                         i, obs, exp_v);
            end
            model_advance();
        end
    endtask

    task automatic test_both_stream();
        logic [3:0] k0;
        logic [3:0] k1;
        int low0;
        int low1;
        k0 = 4'hA;
        k1 = 4'h5;
        low0 = 0;
        low1 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            full = 1'b0;
            in_valid = 2'b11;
            in_data = {k1, k0};
            #1;
            exp_v = model_exp();
            obs = {in_ready, push, push ? grant : 1'b0,
                   push ? data_out : 4'h0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL both_stream cyc %0d: got %b want %b",
                         i, obs, exp_v);
            end
            low0 = in_ready[0] ? 0 : low0 + 1;
            low1 = in_ready[1] ? 0 : low1 + 1;
            n_vec++;
            if (low0 > 2 || low1 > 2) begin
                n_err++;
                $display("FAIL stream_ready cyc %0d: low %0d/%0d want <=2",
                         i, low0, low1);
            end
            if (exp_v[6]) k0 = k0 + 4'd1;
            if (exp_v[7]) k1 = k1 + 4'd1;
            model_advance();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 2'b00;
            #1;
            exp_v = model_exp();
            obs = {in_ready, push, push ? grant : 1'b0,
                   push ? data_out : 4'h0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL stream_drain cyc %0d: got %b want %b",
                         i, obs, exp_v);
            end
            model_advance();
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            full = (i < 6);
            in_valid = (i < 6) ? 2'b11 : 2'b00;
            in_data = 8'($urandom);
            #1;
            exp_v = model_exp();
            obs = {in_ready, push, push ? grant : 1'b0,
                   push ? data_out : 4'h0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL full cyc %0d: got %b want %b",
                         i, obs, exp_v);
            end
            model_advance();
        end
    endtask

    task automatic test_sync_reset();
        logic [1:0] vs [6];
        logic       fs [6];
        logic       rs [6];
        vs = '{2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
        fs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = vs[i];
            full = fs[i];
            sreset = rs[i];
            in_data = 8'($urandom);
            #1;
            exp_v = model_exp();
            obs = {in_ready, push, push ? grant : 1'b0,
                   push ? data_out : 4'h0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL sync_reset cyc %0d: got %b want %b",
                         i, obs, exp_v);
            end
            model_advance();
        end
        sreset = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            full = 1'b1;
            in_valid = 2'b11;
            in_data = 8'($urandom);
            #1;
            model_advance();
        end
        @(negedge clk);
        in_valid = 2'b00;
        full = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        obs = {in_ready, push, push ? grant : 1'b0,
               push ? data_out : 4'h0};
        n_vec++;
        if (obs !== 8'b11_0_0_0000) begin
            n_err++;
            $display("FAIL async_reset: got %b want %b",
                     obs, 8'b11_0_0_0000);
        end
        q0.delete();
        q1.delete();
        rr_m = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 2'b00;
            #1;
            exp_v = model_exp();
            obs = {in_ready, push, push ? grant : 1'b0,
                   push ? data_out : 4'h0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL async_after cyc %0d: got %b want %b",
                         i, obs, exp_v);
            end
            model_advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            full = ($urandom_range(0, 3) == 0);
            in_valid = 2'($urandom);
            in_data = 8'($urandom);
            sreset = ($urandom_range(0, 31) == 0);
            #1;
            exp_v = model_exp();
            obs = {in_ready, push, push ? grant : 1'b0,
                   push ? data_out : 4'h0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b want %b",
                         i, obs, exp_v);
            end
            model_advance();
        end
        sreset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rr_m = 1'b0;
        rst_n = 1'b0;
        sreset = 1'b0;
        in_valid = 2'b00;
        in_data = 8'h00;
        full = 1'b0;
        #12;
        rst_n = 1'b1;
        test_reset();
        test_ch0_only();
        test_both_stream();
        test_full();
        test_sync_reset();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
